// File: rtl/mcu_pkg.sv
// Shared types and constants for the MCU UART transmit arbiter.
// Holds the FSM state encoding, frame opcodes and the frame length field width.
package mcu_pkg;

  localparam int LEN_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SEND,
    ST_WAIT,
    ST_FIN,
    ST_GAP
  } mcu_state_e;

  localparam logic [7:0] OP_STAGE    = 8'h20;
  localparam logic [7:0] OP_VERSION  = 8'h30;
  localparam logic [7:0] OP_IP       = 8'h40;
  localparam logic [7:0] OP_STATUS   = 8'h50;
  localparam logic [7:0] OP_POWER_ON = 8'h60;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned max_len);
    if (32'(len) > max_len) return LEN_W'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/mcu_tx_prio_sel.sv
// Combinational requester selector: searches req starting one past i_ptr (wrapping).
// A fixed pointer of NUM_REQ-1 gives plain lowest-index-wins priority.
module mcu_tx_prio_sel #(
  parameter int NUM_REQ = 4,
  localparam int IDXW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDXW-1:0]    i_ptr,
  output logic [IDXW-1:0]    o_sel,
  output logic               o_vld
);

  always_comb begin
    int k;
    k     = 0;
    o_sel = '0;
    o_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(i_ptr) + 1 + i) % NUM_REQ;
      if (!o_vld && i_req[k]) begin
        o_vld = 1'b1;
        o_sel = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/mcu_tx_arbiter.sv
// Shares the MCU UART transmitter between frame producers: grant, stream bytes, gap.
// Define MCU_TX_RR_EN for round-robin arbitration; default build is fixed priority.
// IDLE wait for req | ARB latch winner/len | SEND strobe byte | WAIT byte done or watchdog
// FIN done pulse, drop grant | GAP inter-frame idle countdown
module mcu_tx_arbiter
  import mcu_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_LEN        = 17,
  parameter int GAP_CYCLES     = 6400,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     req_data,
  output logic [LEN_W-1:0]         byte_idx,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     uart_tx_dv,
  output logic [7:0]               uart_tx_byte,
  input  logic                     uart_tx_done,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IDXW  = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  mcu_state_e         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic               r_dv, w_dv_nxt;
  logic [7:0]         r_byte, w_byte_nxt;
  logic [LEN_W-1:0]   r_idx, w_idx_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [IDXW-1:0]    r_win, w_win_nxt;
  logic [WD_W-1:0]    r_wdog, w_wdog_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               r_terr, w_terr_nxt;

  logic [IDXW-1:0]    w_ptr;
  logic [IDXW-1:0]    w_sel;
  logic               w_sel_vld;
  logic [LEN_W-1:0]   w_sel_len;
  logic [7:0]         w_req_byte;
  logic [LEN_W-1:0]   w_idx_inc;
  logic [WD_W-1:0]    w_wdog_inc;

`ifdef MCU_TX_RR_EN
  logic [IDXW-1:0] r_ptr;

  // Pointer starts at the last index so requester 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= IDXW'(NUM_REQ - 1);
    else if (r_state == ST_ARB && w_sel_vld) r_ptr <= w_sel;
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = IDXW'(NUM_REQ - 1);
`endif

  mcu_tx_prio_sel #(.NUM_REQ(NUM_REQ)) u_sel (
    .i_req (req),
    .i_ptr (w_ptr),
    .o_sel (w_sel),
    .o_vld (w_sel_vld)
  );

  assign w_sel_len  = req_len[w_sel*LEN_W +: LEN_W];
  assign w_req_byte = req_data[r_win*8 +: 8];
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_wdog_inc = (r_wdog == WD_W'(TIMEOUT_CYCLES)) ? r_wdog : r_wdog + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_dv_nxt    = 1'b0;
    w_byte_nxt  = r_byte;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_win_nxt   = r_win;
    w_wdog_nxt  = r_wdog;
    w_gap_nxt   = r_gap;
    w_terr_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: if (|req) w_state_nxt = ST_ARB;
      ST_ARB: begin
        // A request can vanish between IDLE and ARB; fall back rather than grant nobody.
        if (w_sel_vld) begin
          w_win_nxt   = w_sel;
          w_gnt_nxt   = NUM_REQ'(1) << w_sel;
          w_idx_nxt   = '0;
          w_len_nxt   = clamp_len(w_sel_len, MAX_LEN);
          w_state_nxt = (w_len_nxt == '0) ? ST_FIN : ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        w_byte_nxt  = w_req_byte;
        w_dv_nxt    = 1'b1;
        w_wdog_nxt  = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (uart_tx_done) begin
          w_idx_nxt   = w_idx_inc;
          w_state_nxt = (w_idx_inc == r_len) ? ST_FIN : ST_SEND;
        end else begin
          w_wdog_nxt = w_wdog_inc;
          if (w_wdog_inc == WD_W'(TIMEOUT_CYCLES)) begin
            w_terr_nxt  = 1'b1;
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        w_done_nxt  = r_gnt;
        w_gnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_gap_nxt   = GAP_W'(GAP_CYCLES - 1);
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap == '0) w_state_nxt = ST_IDLE;
        else w_gap_nxt = r_gap - 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_dv    <= 1'b0;
      r_byte  <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_win   <= '0;
      r_wdog  <= '0;
      r_gap   <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_dv    <= w_dv_nxt;
      r_byte  <= w_byte_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_win   <= w_win_nxt;
      r_wdog  <= w_wdog_nxt;
      r_gap   <= w_gap_nxt;
      r_terr  <= w_terr_nxt;
    end
  end

  assign byte_idx     = r_idx;
  assign gnt          = r_gnt;
  assign done         = r_done;
  assign uart_tx_dv   = r_dv;
  assign uart_tx_byte = r_byte;
  assign busy         = (r_state != ST_IDLE);
  assign timeout_err  = r_terr;

endmodule
